// File: rtl/saes_pkg.sv
// Shared types, constants and GF(2^4) / nibble helpers for the iterative S-AES core.
package saes_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD0 = 3'd1,
        RND1 = 3'd2,
        RND2 = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Step selector for the shared round datapath
    localparam logic [1:0] STEP_ADD  = 2'd0;
    localparam logic [1:0] STEP_RND1 = 2'd1;
    localparam logic [1:0] STEP_RND2 = 2'd2;

    // Forward nibble substitution table
    function automatic logic [3:0] sbox_enc(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'h9;  4'h1: r = 4'h4;  4'h2: r = 4'hA;  4'h3: r = 4'hB;
            4'h4: r = 4'hD;  4'h5: r = 4'h1;  4'h6: r = 4'h8;  4'h7: r = 4'h5;
            4'h8: r = 4'h6;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'h3;
            4'hC: r = 4'hC;  4'hD: r = 4'hE;  4'hE: r = 4'hF;  4'hF: r = 4'h7;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    // Inverse nibble substitution table
    function automatic logic [3:0] sbox_dec(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'hA;  4'h1: r = 4'h5;  4'h2: r = 4'h9;  4'h3: r = 4'hB;
            4'h4: r = 4'h1;  4'h5: r = 4'h7;  4'h6: r = 4'h8;  4'h7: r = 4'hF;
            4'h8: r = 4'h6;  4'h9: r = 4'h0;  4'hA: r = 4'h2;  4'hB: r = 4'h3;
            4'hC: r = 4'hC;  4'hD: r = 4'h4;  4'hE: r = 4'hD;  4'hF: r = 4'hE;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    // Byte-wide forward substitution used by the key expansion
    function automatic logic [7:0] sub_nib(input logic [7:0] w);
        return {sbox_enc(w[7:4]), sbox_enc(w[3:0])};
    endfunction

    // GF(2^4) multiply, reduction polynomial x^4+x+1
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            else      acc = acc;
            if (sh[3]) sh = {sh[2:0], 1'b0} ^ 4'h3;
            else       sh = {sh[2:0], 1'b0};
        end
        return acc;
    endfunction

    // Self-inverse: exchange the two bottom-row nibbles
    function automatic logic [15:0] shift_rows(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [15:0] mix_col(input logic [15:0] s);
        return {s[15:12] ^ gf16_mul(4'h4, s[11:8]), gf16_mul(4'h4, s[15:12]) ^ s[11:8],
                s[7:4]   ^ gf16_mul(4'h4, s[3:0]),  gf16_mul(4'h4, s[7:4])   ^ s[3:0]};
    endfunction

    function automatic logic [15:0] inv_mix_col(input logic [15:0] s);
        return {gf16_mul(4'h9, s[15:12]) ^ gf16_mul(4'h2, s[11:8]),
                gf16_mul(4'h2, s[15:12]) ^ gf16_mul(4'h9, s[11:8]),
                gf16_mul(4'h9, s[7:4])   ^ gf16_mul(4'h2, s[3:0]),
                gf16_mul(4'h2, s[7:4])   ^ gf16_mul(4'h9, s[3:0])};
    endfunction

endpackage

// File: rtl/KeySchedule.sv
// Combinational S-AES key expansion: 16-bit key -> round keys k1, k2.
module KeySchedule
    import saes_pkg::*;
(
    input  logic [15:0] key,
    output logic [15:0] k1,
    output logic [15:0] k2
);
    logic [7:0] w2_s;
    logic [7:0] w3_s;
    logic [7:0] w4_s;
    logic [7:0] w5_s;

    // RotNib is a nibble swap, folded into the sub_nib argument
    assign w2_s = key[15:8] ^ 8'h80 ^ sub_nib({key[3:0], key[7:4]});
    assign w3_s = w2_s ^ key[7:0];
    assign w4_s = w2_s ^ 8'h30 ^ sub_nib({w3_s[3:0], w3_s[7:4]});
    assign w5_s = w4_s ^ w3_s;
    assign k1   = {w2_s, w3_s};
    assign k2   = {w4_s, w5_s};
endmodule

// File: rtl/saes_round.sv
// Shared combinational round step for encrypt and decrypt.
module saes_round
    import saes_pkg::*;
(
    input  logic [15:0] s,
    input  logic [15:0] rk,
    input  logic        mode,
    input  logic [1:0]  step,
    output logic [15:0] s_next
);
    logic [15:0] dec_in_s;
    logic [15:0] enc_sub_s;
    logic [15:0] dec_sub_s;

    // Decrypt substitutes after the row shift, encrypt before it
    assign dec_in_s = shift_rows(s);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign enc_sub_s[4*i +: 4] = sbox_enc(s[4*i +: 4]);
        assign dec_sub_s[4*i +: 4] = sbox_dec(dec_in_s[4*i +: 4]);
    end

    // Select the transform for this step and direction
    always_comb begin
        s_next = s;
        case (step)
            STEP_ADD: s_next = s ^ rk;
            STEP_RND1: begin
                if (mode == MODE_DEC) s_next = inv_mix_col(dec_sub_s ^ rk);
                else                  s_next = mix_col(shift_rows(enc_sub_s)) ^ rk;
            end
            STEP_RND2: begin
                if (mode == MODE_DEC) s_next = dec_sub_s ^ rk;
                else                  s_next = shift_rows(enc_sub_s) ^ rk;
            end
            default: s_next = s;
        endcase
    end
endmodule

// File: rtl/saes_iterative_core.sv
// Iterative S-AES engine: one job per handshake, three round steps on a shared datapath.
module saes_iterative_core
    import saes_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [15:0]      in_key,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_mode,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    state_e           state_r;
    state_e           next_state_s;
    logic [15:0]      s_r;
    logic [15:0]      key_r;
    logic             mode_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [CNT_W-1:0] op_count_r;
    logic             in_ready_s;
    logic [1:0]       step_s;
    logic [15:0]      rk_s;
    logic [15:0]      k1_s;
    logic [15:0]      k2_s;
    logic [15:0]      round_out_s;
    logic             accept_s;
    logic             handoff_s;

    KeySchedule u_key_schedule (
        .key (key_r),
        .k1  (k1_s),
        .k2  (k2_s)
    );

    saes_round u_round (
        .s      (s_r),
        .rk     (rk_s),
        .mode   (mode_r),
        .step   (step_s),
        .s_next (round_out_s)
    );

    assign accept_s  = in_valid & in_ready_s;
    assign handoff_s = out_valid_r & out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Next-state, round-key and step selection; in_ready must react to out_ready this cycle
    always_comb begin
        next_state_s = state_r;
        in_ready_s   = 1'b0;
        step_s       = STEP_ADD;
        rk_s         = key_r;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) next_state_s = ADD0;
                else          next_state_s = IDLE;
            end
            ADD0: begin
                step_s       = STEP_ADD;
                rk_s         = (mode_r == MODE_DEC) ? k2_s : key_r;
                next_state_s = RND1;
            end
            RND1: begin
                step_s       = STEP_RND1;
                rk_s         = k1_s;
                next_state_s = RND2;
            end
            RND2: begin
                step_s       = STEP_RND2;
                rk_s         = (mode_r == MODE_DEC) ? key_r : k2_s;
                next_state_s = DONE;
            end
            DONE: begin
                in_ready_s = out_ready;
                if (out_ready) next_state_s = in_valid ? ADD0 : IDLE;
                else           next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Job capture and round-state update
    always_ff @(posedge clk) begin
        if (reset) begin
            s_r    <= 16'h0000;
            key_r  <= 16'h0000;
            mode_r <= MODE_ENC;
        end else if (accept_s) begin
            s_r    <= in_data;
            key_r  <= in_key;
            mode_r <= in_mode;
        end else if (state_r == ADD0 || state_r == RND1 || state_r == RND2) begin
            s_r <= round_out_s;
        end else begin
            s_r <= s_r;
        end
    end

    // Registered status flags derived from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= (next_state_s == DONE);
            busy_r      <= (next_state_s != IDLE);
        end
    end

    // Completed-handoff counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset)          op_count_r <= '0;
        else if (handoff_s) op_count_r <= op_count_r + CNT_W'(1);
        else                op_count_r <= op_count_r;
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = s_r;
    assign out_mode  = mode_r;
    assign busy      = busy_r;
    assign op_count  = op_count_r;
endmodule
